// File: rtl/cdc_2phase_src_arb_if.sv
// Requester-side and CDC-side handshake bundle for cdc_2phase_src_arb.
// The slave modport is the arbiter's view; master is the driver/monitor view.
interface cdc_2phase_src_arb_if #(
  parameter int NumIn     = 4,
  parameter int DataWidth = 32
);
  localparam int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1;

  logic [NumIn*DataWidth-1:0]      req_data_i;
  logic [NumIn-1:0]                req_valid_i;
  logic [NumIn-1:0]                req_ready_o;
  logic [IdxWidth+DataWidth-1:0]   cdc_data_o;
  logic                            cdc_valid_o;
  logic                            cdc_ready_i;
  logic                            busy_o;
  logic                            timeout_o;

  modport slave (
    input  req_data_i, req_valid_i, cdc_ready_i,
    output req_ready_o, cdc_data_o, cdc_valid_o, busy_o, timeout_o
  );

  modport master (
    output req_data_i, req_valid_i, cdc_ready_i,
    input  req_ready_o, cdc_data_o, cdc_valid_o, busy_o, timeout_o
  );
endinterface

// File: rtl/cdc_2phase_src_arb.sv
// Round-robin arbiter sharing one two-phase CDC source channel among NumIn requesters.
// Optional stall watchdog enabled by defining CDC_2PHASE_SRC_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no grant held; round-robin pick from rr_ptr_q each cycle
// LOCKED | grant held on gnt_idx_q until the CDC accepts it (or valid drops)
module cdc_2phase_src_arb #(
  parameter int NumIn         = 4,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  cdc_2phase_src_arb_if.slave  bus
);
  localparam int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumIn - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IdxWidth-1:0]   gnt;
  logic [DataWidth-1:0]  gnt_data;
  logic                  cdc_valid;
  logic                  hs;

  // Iterating downward lets the closest valid requester after ptr win.
  function automatic logic [IdxWidth-1:0] rr_pick(input logic [NumIn-1:0] valid,
                                                  input logic [IdxWidth-1:0] ptr);
    logic [IdxWidth-1:0] pick;
    int unsigned k;
    pick = ptr;
    for (int i = NumIn - 1; i >= 0; i--) begin
      k = (32'(ptr) + 32'(i)) % 32'(NumIn);
      if (|(valid & (NumIn'(1) << k))) pick = k[IdxWidth-1:0];
    end
    return pick;
  endfunction

  function automatic logic [IdxWidth-1:0] next_ptr(input logic [IdxWidth-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt       = rr_pick(bus.req_valid_i, rr_ptr_q);
    cdc_valid = |bus.req_valid_i;
    unique case (state_q)
      IDLE: begin
        if (cdc_valid) begin
          if (bus.cdc_ready_i) begin
            rr_ptr_d = next_ptr(gnt);
          end else begin
            gnt_idx_d = gnt;
            state_d   = LOCKED;
          end
        end
      end
      LOCKED: begin
        gnt       = gnt_idx_q;
        cdc_valid = |(bus.req_valid_i & (NumIn'(1) << gnt_idx_q));
        // A dropped valid is a protocol violation: release without advancing the pointer.
        if (!cdc_valid) begin
          state_d = IDLE;
        end else if (bus.cdc_ready_i) begin
          rr_ptr_d = next_ptr(gnt_idx_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NumIn; k++) begin
      if (gnt == IdxWidth'(k)) gnt_data = bus.req_data_i[k*DataWidth +: DataWidth];
    end
  end

  assign hs              = cdc_valid & bus.cdc_ready_i;
  assign bus.cdc_valid_o = cdc_valid;
  assign bus.cdc_data_o  = {gnt, gnt_data};
  assign bus.req_ready_o = hs ? (NumIn'(1) << gnt) : '0;
  assign bus.busy_o      = (state_q == LOCKED);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

`ifdef CDC_2PHASE_SRC_ARB_TIMEOUT_EN
  localparam int StallWidth = $clog2(TimeoutCycles + 1);
  localparam logic [StallWidth-1:0] StallMax = StallWidth'(TimeoutCycles);

  logic [StallWidth-1:0] stall_q, stall_d;
  logic                  timeout_q;

  always_comb begin
    stall_d = '0;
    if (cdc_valid && !bus.cdc_ready_i) begin
      stall_d = (stall_q == StallMax) ? stall_q : stall_q + 1'b1;
    end
  end

  // Flag rises on the same edge the counter reaches its limit, then sticks.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_q | (stall_d == StallMax);
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign bus.timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_cdc_2phase_src_arb.sv
// Directed self-checking bench for cdc_2phase_src_arb (NumIn=4 main instance,
// NumIn=1 degenerate instance).
module tb_cdc_2phase_src_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  int   errors = 0;
  int   checks = 0;

`ifdef CDC_2PHASE_SRC_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  always #5 clk = ~clk;

  cdc_2phase_src_arb_if #(.NumIn(4), .DataWidth(32)) bus ();
  cdc_2phase_src_arb_if #(.NumIn(1), .DataWidth(8))  bus1 ();

  cdc_2phase_src_arb #(.NumIn(4), .DataWidth(32), .TimeoutCycles(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (clr),
    .bus   (bus.slave)
  );

  cdc_2phase_src_arb #(.NumIn(1), .DataWidth(8)) dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (clr),
    .bus   (bus1.slave)
  );

  function automatic logic [31:0] dval(input int k);
    return 32'(32'h1111_1111 * (k + 1));
  endfunction

  function automatic logic [33:0] exp_data(input int k);
    return {2'(k), dval(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    bus.req_valid_i  = '0;
    bus.cdc_ready_i  = 1'b0;
    bus1.req_valid_i = '0;
    bus1.cdc_ready_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid_i = '0;
    bus.cdc_ready_i = 1'b1;
    tick();
    checks++;
    if ({bus.cdc_valid_o, bus.req_ready_o, bus.cdc_data_o, bus.busy_o, bus.timeout_o}
        !== {1'b0, 4'b0000, exp_data(0), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got v=%b rdy=%b data=%h busy=%b to=%b exp v=0 rdy=0000 data=%h busy=0 to=0",
               bus.cdc_valid_o, bus.req_ready_o, bus.cdc_data_o, bus.busy_o, bus.timeout_o, exp_data(0));
    end
    checks++;
    if ({bus1.cdc_valid_o, bus1.req_ready_o, bus1.busy_o, bus1.cdc_data_o} !== {1'b0, 1'b0, 1'b0, 9'h0A5}) begin
      errors++;
      $display("FAIL reset_single got v=%b rdy=%b busy=%b data=%h exp v=0 rdy=0 busy=0 data=0a5",
               bus1.cdc_valid_o, bus1.req_ready_o, bus1.busy_o, bus1.cdc_data_o);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req_valid_i = 4'b1111;
    bus.cdc_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({bus.cdc_valid_o, bus.req_ready_o, bus.cdc_data_o, bus.busy_o}
          !== {1'b1, 4'(1 << (i % 4)), exp_data(i % 4), 1'b0}) begin
        errors++;
        $display("FAIL rr_grant step=%0d got v=%b rdy=%b data=%h busy=%b exp rdy=%b data=%h",
                 i, bus.cdc_valid_o, bus.req_ready_o, bus.cdc_data_o, bus.busy_o,
                 4'(1 << (i % 4)), exp_data(i % 4));
      end
      tick();
    end
    bus.req_valid_i = '0;
  endtask

  task automatic test_lock();
    do_reset();
    bus.req_valid_i = 4'b0101;
    bus.cdc_ready_i = 1'b0;
    #1;
    checks++;
    if ({bus.cdc_valid_o, bus.req_ready_o, bus.cdc_data_o, bus.busy_o} !== {1'b1, 4'b0000, exp_data(0), 1'b0}) begin
      errors++;
      $display("FAIL lock_first got v=%b rdy=%b data=%h busy=%b exp v=1 rdy=0000 data=%h busy=0",
               bus.cdc_valid_o, bus.req_ready_o, bus.cdc_data_o, bus.busy_o, exp_data(0));
    end
    for (int c = 1; c < 5; c++) begin
      tick();
      checks++;
      if ({bus.cdc_valid_o, bus.req_ready_o, bus.cdc_data_o, bus.busy_o} !== {1'b1, 4'b0000, exp_data(0), 1'b1}) begin
        errors++;
        $display("FAIL lock_hold cycle=%0d got v=%b rdy=%b data=%h busy=%b exp v=1 rdy=0000 data=%h busy=1",
                 c, bus.cdc_valid_o, bus.req_ready_o, bus.cdc_data_o, bus.busy_o, exp_data(0));
      end
    end
    tick();
    bus.cdc_ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready_o, bus.cdc_data_o, bus.busy_o} !== {4'b0001, exp_data(0), 1'b1}) begin
      errors++;
      $display("FAIL lock_release got rdy=%b data=%h busy=%b exp rdy=0001 data=%h busy=1",
               bus.req_ready_o, bus.cdc_data_o, bus.busy_o, exp_data(0));
    end
    tick();
    bus.req_valid_i = 4'b0100;
    #1;
    checks++;
    if ({bus.req_ready_o, bus.cdc_data_o, bus.busy_o} !== {4'b0100, exp_data(2), 1'b0}) begin
      errors++;
      $display("FAIL lock_next got rdy=%b data=%h busy=%b exp rdy=0100 data=%h busy=0",
               bus.req_ready_o, bus.cdc_data_o, bus.busy_o, exp_data(2));
    end
    tick();
    bus.req_valid_i = '0;
    bus.cdc_ready_i = 1'b0;
  endtask

  task automatic test_no_preempt();
    do_reset();
    bus.req_valid_i = 4'b0010;
    bus.cdc_ready_i = 1'b0;
    tick();
    bus.req_valid_i = 4'b1010;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({bus.cdc_valid_o, bus.cdc_data_o, bus.busy_o} !== {1'b1, exp_data(1), 1'b1}) begin
        errors++;
        $display("FAIL preempt_hold cycle=%0d got v=%b data=%h busy=%b exp v=1 data=%h busy=1",
                 c, bus.cdc_valid_o, bus.cdc_data_o, bus.busy_o, exp_data(1));
      end
      tick();
    end
    bus.cdc_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL preempt_release got rdy=%b exp rdy=0010", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 4'b1001;
    #1;
    checks++;
    if ({bus.req_ready_o, bus.cdc_data_o, bus.busy_o} !== {4'b1000, exp_data(3), 1'b0}) begin
      errors++;
      $display("FAIL preempt_after got rdy=%b data=%h busy=%b exp rdy=1000 data=%h busy=0",
               bus.req_ready_o, bus.cdc_data_o, bus.busy_o, exp_data(3));
    end
    tick();
    bus.req_valid_i = '0;
    bus.cdc_ready_i = 1'b0;
  endtask

  task automatic test_clear();
    do_reset();
    bus.req_valid_i = 4'b0010;
    bus.cdc_ready_i = 1'b1;
    tick();
    bus.req_valid_i = 4'b0100;
    bus.cdc_ready_i = 1'b0;
    tick();
    checks++;
    if ({bus.cdc_data_o, bus.busy_o} !== {exp_data(2), 1'b1}) begin
      errors++;
      $display("FAIL clear_locked got data=%h busy=%b exp data=%h busy=1", bus.cdc_data_o, bus.busy_o, exp_data(2));
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy got busy=%b exp busy=0", bus.busy_o);
    end
    bus.req_valid_i = 4'b1111;
    bus.cdc_ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready_o, bus.cdc_data_o} !== {4'b0001, exp_data(0)}) begin
      errors++;
      $display("FAIL clear_ptr got rdy=%b data=%h exp rdy=0001 data=%h", bus.req_ready_o, bus.cdc_data_o, exp_data(0));
    end
    tick();
    bus.req_valid_i = '0;
    bus.cdc_ready_i = 1'b0;
  endtask

  task automatic test_violation();
    do_reset();
    bus.req_valid_i = 4'b0010;
    bus.cdc_ready_i = 1'b0;
    tick();
    bus.req_valid_i = 4'b0000;
    bus.cdc_ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.cdc_valid_o, bus.req_ready_o, bus.busy_o} !== {1'b0, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL viol_drop got v=%b rdy=%b busy=%b exp v=0 rdy=0000 busy=1",
               bus.cdc_valid_o, bus.req_ready_o, bus.busy_o);
    end
    tick();
    bus.req_valid_i = 4'b1111;
    #1;
    checks++;
    if ({bus.busy_o, bus.req_ready_o, bus.cdc_data_o} !== {1'b0, 4'b0001, exp_data(0)}) begin
      errors++;
      $display("FAIL viol_after got busy=%b rdy=%b data=%h exp busy=0 rdy=0001 data=%h",
               bus.busy_o, bus.req_ready_o, bus.cdc_data_o, exp_data(0));
    end
    tick();
    bus.req_valid_i = '0;
    bus.cdc_ready_i = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus1.req_valid_i = 1'b1;
    bus1.cdc_ready_i = 1'b1;
    #1;
    checks++;
    if ({bus1.cdc_valid_o, bus1.req_ready_o, bus1.cdc_data_o, bus1.busy_o} !== {1'b1, 1'b1, 9'h0A5, 1'b0}) begin
      errors++;
      $display("FAIL single_pass got v=%b rdy=%b data=%h busy=%b exp v=1 rdy=1 data=0a5 busy=0",
               bus1.cdc_valid_o, bus1.req_ready_o, bus1.cdc_data_o, bus1.busy_o);
    end
    bus1.cdc_ready_i = 1'b0;
    #1;
    checks++;
    if (bus1.req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL single_notready got rdy=%b exp rdy=0", bus1.req_ready_o);
    end
    tick();
    checks++;
    if ({bus1.busy_o, bus1.cdc_data_o} !== {1'b1, 9'h0A5}) begin
      errors++;
      $display("FAIL single_lock got busy=%b data=%h exp busy=1 data=0a5", bus1.busy_o, bus1.cdc_data_o);
    end
    bus1.cdc_ready_i = 1'b1;
    #1;
    checks++;
    if (bus1.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL single_release got rdy=%b exp rdy=1", bus1.req_ready_o);
    end
    bus1.req_valid_i = 1'b0;
    tick();
    checks++;
    if (bus1.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got busy=%b exp busy=0", bus1.busy_o);
    end
    bus1.cdc_ready_i = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req_valid_i = 4'b0001;
    bus.cdc_ready_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (bus.timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early stall=%0d got to=%b exp to=0", c, bus.timeout_o);
      end
    end
    tick();
    checks++;
    if (bus.timeout_o !== TimeoutEn) begin
      errors++;
      $display("FAIL timeout_set got to=%b exp to=%b", bus.timeout_o, TimeoutEn);
    end
    bus.cdc_ready_i = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.timeout_o !== TimeoutEn) begin
      errors++;
      $display("FAIL timeout_sticky got to=%b exp to=%b", bus.timeout_o, TimeoutEn);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (bus.timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got to=%b exp to=0", bus.timeout_o);
    end
    bus.req_valid_i = '0;
    bus.cdc_ready_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    bus.req_data_i   = {dval(3), dval(2), dval(1), dval(0)};
    bus.req_valid_i  = '0;
    bus.cdc_ready_i  = 1'b0;
    bus1.req_data_i  = 8'hA5;
    bus1.req_valid_i = '0;
    bus1.cdc_ready_i = 1'b0;

    test_reset();
    test_round_robin();
    test_lock();
    test_no_preempt();
    test_clear();
    test_violation();
    test_single();
    test_timeout();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
